// File: rtl/signed_bcd_display.sv
// Serial binary-to-BCD converter (double-dabble, one bit per clock) with sign
// handling, overflow saturation and per-digit seven-segment decode.

module seven_segment (
    input  logic [3:0] digit,
    input  logic       blank,
    output logic [6:0] seg
);
    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    always_comb begin
        seg = 7'b1111111;
        if (!blank) begin
            case (digit)
                4'd0:    seg = 7'b1000000;
                4'd1:    seg = 7'b1111001;
                4'd2:    seg = 7'b0100100;
                4'd3:    seg = 7'b0110000;
                4'd4:    seg = 7'b0011001;
                4'd5:    seg = 7'b0010010;
                4'd6:    seg = 7'b0000010;
                4'd7:    seg = 7'b1111000;
                4'd8:    seg = 7'b0000000;
                4'd9:    seg = 7'b0010000;
                default: seg = 7'b1111111;
            endcase
        end
    end
endmodule

module signed_bcd_display #(
    parameter int WIDTH       = 8,
    parameter int DIGITS      = 3,
    parameter int SIGNED_MODE = 1,
    parameter int BLANK_LZ    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      val,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg7,
    output logic [6:0]            seg7_sign
);
    localparam int BW    = 4 * (DIGITS + 1);
    localparam int OW    = 4 * DIGITS;
    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, CONVERT, FINISH} state_t;

    function automatic logic [BW-1:0] dabble_adj(input logic [BW-1:0] b);
        logic [BW-1:0] r;
        r = b;
        for (int i = 0; i <= DIGITS; i++) begin
            if (r[4*i +: 4] >= 4'd5) r[4*i +: 4] = r[4*i +: 4] + 4'd3;
        end
        return r;
    endfunction

    function automatic logic [OW-1:0] sat_bcd(input logic ovf, input logic [OW-1:0] raw);
        logic [OW-1:0] r;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = ovf ? 4'd9 : raw[4*i +: 4];
        end
        return r;
    endfunction

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [BW-1:0]         bcd_sh, bcd_adj;
    logic [WIDTH-1:0]      mag_sh, mag_in;
    logic signed [WIDTH-1:0] val_s;
    logic                  sign_sh, sign_in, carry_sh, ovf_now;
    logic [DIGITS-1:0]     blank_d;
    logic                  hi_zero;

    assign val_s   = val;
    assign sign_in = (SIGNED_MODE != 0) && val_s[WIDTH-1];
    // Negating the most negative value wraps to 2^(WIDTH-1), which is the true magnitude.
    assign mag_in  = sign_in ? WIDTH'($unsigned(-val_s)) : val;
    assign bcd_adj = dabble_adj(bcd_sh);
    // carry_sh catches digits pushed out of the top nibble on wide inputs.
    assign ovf_now = carry_sh | (bcd_sh[BW-1 -: 4] != 4'd0);
    assign busy    = (state == CONVERT);

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = CONVERT;
            CONVERT: if (cnt == LAST) state_nxt = FINISH;
            FINISH:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt      <= '0;
            bcd_sh   <= '0;
            mag_sh   <= '0;
            sign_sh  <= 1'b0;
            carry_sh <= 1'b0;
            done     <= 1'b0;
            neg      <= 1'b0;
            overflow <= 1'b0;
            bcd      <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    cnt      <= '0;
                    bcd_sh   <= '0;
                    mag_sh   <= mag_in;
                    sign_sh  <= sign_in;
                    carry_sh <= 1'b0;
                end
                CONVERT: begin
                    {bcd_sh, mag_sh} <= {bcd_adj[BW-2:0], mag_sh, 1'b0};
                    carry_sh         <= carry_sh | bcd_adj[BW-1];
                    cnt              <= cnt + 1'b1;
                end
                FINISH: begin
                    done     <= 1'b1;
                    neg      <= sign_sh;
                    overflow <= ovf_now;
                    bcd      <= sat_bcd(ovf_now, bcd_sh[OW-1:0]);
                end
                default: ;
            endcase
        end
    end

    // A digit blanks only if it and everything above it is zero; units never blank.
    always_comb begin
        hi_zero = 1'b1;
        blank_d = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            hi_zero    = hi_zero & (bcd[4*k +: 4] == 4'd0);
            blank_d[k] = (BLANK_LZ != 0) && (k != 0) && hi_zero;
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_seg
        seven_segment u_seg (
            .digit (bcd[4*g +: 4]),
            .blank (blank_d[g]),
            .seg   (seg7[7*g +: 7])
        );
    end

    assign seg7_sign = neg ? 7'b0111111 : 7'b1111111;

endmodule

// File: tb/tb_signed_bcd_display.sv
// Bench: four parameter variants driven in lockstep, checked against an
// arithmetic decimal model.

module tb_signed_bcd_display;
    typedef struct packed {
        logic        neg;
        logic        ovf;
        logic [19:0] bcd;
    } res_t;

    logic clk, rst, start;
    logic [7:0] val;
    int checks = 0;
    int failures = 0;

    logic busy_d, done_d, neg_d, ovf_d; logic [11:0] bcd_d; logic [20:0] seg_d; logic [6:0] sgn_d;
    logic busy_u, done_u, neg_u, ovf_u; logic [11:0] bcd_u; logic [20:0] seg_u; logic [6:0] sgn_u;
    logic busy_2, done_2, neg_2, ovf_2; logic [7:0]  bcd_2; logic [13:0] seg_2; logic [6:0] sgn_2;
    logic busy_b, done_b, neg_b, ovf_b; logic [11:0] bcd_b; logic [20:0] seg_b; logic [6:0] sgn_b;

    res_t e_d, e_u, e_2, e_b;

    signed_bcd_display u_def (.clk(clk), .rst(rst), .start(start), .val(val), .busy(busy_d),
        .done(done_d), .neg(neg_d), .overflow(ovf_d), .bcd(bcd_d), .seg7(seg_d), .seg7_sign(sgn_d));
    signed_bcd_display #(.SIGNED_MODE(0)) u_uns (.clk(clk), .rst(rst), .start(start), .val(val),
        .busy(busy_u), .done(done_u), .neg(neg_u), .overflow(ovf_u), .bcd(bcd_u), .seg7(seg_u),
        .seg7_sign(sgn_u));
    signed_bcd_display #(.DIGITS(2)) u_d2 (.clk(clk), .rst(rst), .start(start), .val(val),
        .busy(busy_2), .done(done_2), .neg(neg_2), .overflow(ovf_2), .bcd(bcd_2), .seg7(seg_2),
        .seg7_sign(sgn_2));
    signed_bcd_display #(.BLANK_LZ(1)) u_blz (.clk(clk), .rst(rst), .start(start), .val(val),
        .busy(busy_b), .done(done_b), .neg(neg_b), .overflow(ovf_b), .bcd(bcd_b), .seg7(seg_b),
        .seg7_sign(sgn_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic res_t model(input logic [7:0] v, input bit sm, input int digits);
        res_t r;
        int mag, lim, p;
        r.neg = sm && v[7];
        mag = r.neg ? 256 - int'(v) : int'(v);
        lim = 1;
        for (int i = 0; i < digits; i++) lim = lim * 10;
        r.ovf = (mag > lim - 1);
        r.bcd = '0;
        p = 1;
        for (int k = 0; k < digits; k++) begin
            r.bcd[4*k +: 4] = r.ovf ? 4'd9 : 4'((mag / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic [6:0] seg_tab(input logic [3:0] d);
        logic [6:0] t [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
        return (d < 10) ? t[d] : 7'b1111111;
    endfunction

    function automatic logic [34:0] build_seg(input logic [19:0] b, input int digits, input bit blz);
        logic [34:0] s;
        bit all_zero_above;
        s = '0;
        for (int k = 0; k < digits; k++) begin
            all_zero_above = 1'b1;
            for (int j = k; j < digits; j++) if (b[4*j +: 4] != 0) all_zero_above = 1'b0;
            s[7*k +: 7] = (blz && k > 0 && all_zero_above) ? 7'b1111111 : seg_tab(b[4*k +: 4]);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_expect(input logic [7:0] v);
        e_d = model(v, 1, 3);
        e_u = model(v, 0, 3);
        e_2 = model(v, 1, 2);
        e_b = model(v, 1, 3);
    endtask

    task automatic check_all(input string tag);
        logic [34:0] s;
        chk({tag, "/d_neg"}, 64'(neg_d), 64'(e_d.neg));
        chk({tag, "/d_ovf"}, 64'(ovf_d), 64'(e_d.ovf));
        chk({tag, "/d_bcd"}, 64'(bcd_d), 64'(e_d.bcd[11:0]));
        s = build_seg(e_d.bcd, 3, 0);
        chk({tag, "/d_seg"}, 64'(seg_d), 64'(s[20:0]));
        chk({tag, "/d_sgn"}, 64'(sgn_d), 64'(e_d.neg ? 7'b0111111 : 7'b1111111));
        chk({tag, "/u_neg"}, 64'(neg_u), 64'(e_u.neg));
        chk({tag, "/u_bcd"}, 64'(bcd_u), 64'(e_u.bcd[11:0]));
        chk({tag, "/u_ovf"}, 64'(ovf_u), 64'(e_u.ovf));
        chk({tag, "/u_sgn"}, 64'(sgn_u), 64'(e_u.neg ? 7'b0111111 : 7'b1111111));
        chk({tag, "/2_neg"}, 64'(neg_2), 64'(e_2.neg));
        chk({tag, "/2_ovf"}, 64'(ovf_2), 64'(e_2.ovf));
        chk({tag, "/2_bcd"}, 64'(bcd_2), 64'(e_2.bcd[7:0]));
        s = build_seg(e_2.bcd, 2, 0);
        chk({tag, "/2_seg"}, 64'(seg_2), 64'(s[13:0]));
        chk({tag, "/b_bcd"}, 64'(bcd_b), 64'(e_b.bcd[11:0]));
        s = build_seg(e_b.bcd, 3, 1);
        chk({tag, "/b_seg"}, 64'(seg_b), 64'(s[20:0]));
    endtask

    task automatic run_conv(input logic [7:0] v, input string tag);
        int n;
        @(negedge clk); val = v; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; val = 8'($urandom);
        chk({tag, "/busy_start"}, 64'(busy_d), 64'd1);
        n = 0;
        while (done_d !== 1'b1 && n < 20) begin
            @(posedge clk); n++; @(negedge clk);
            if (n == 4) begin
                chk({tag, "/hold_bcd"}, 64'(bcd_d), 64'(e_d.bcd[11:0]));
                chk({tag, "/hold_done"}, 64'(done_d), 64'd0);
            end
            if (n == 7) chk({tag, "/busy_last"}, 64'(busy_d), 64'd1);
            if (n == 8) chk({tag, "/busy_finish"}, 64'(busy_d), 64'd0);
        end
        chk({tag, "/latency"}, 64'(n), 64'd9);
        set_expect(v);
        check_all(tag);
        chk({tag, "/done_all"}, 64'({done_d, done_u, done_2, done_b}), 64'hF);
        chk({tag, "/busy_done"}, 64'(busy_d), 64'd0);
        @(posedge clk); @(negedge clk);
        chk({tag, "/done_pulse"}, 64'(done_d), 64'd0);
    endtask

    initial begin
        int n, m, dones, first;
        rst = 1'b0; start = 1'b1; val = 8'h9C;
        repeat (3) @(posedge clk);
        @(negedge clk);
        e_d = '0; e_u = '0; e_2 = '0; e_b = '0;
        chk("reset/busy", 64'(busy_d), 64'd0);
        chk("reset/done", 64'(done_d), 64'd0);
        check_all("reset");
        rst = 1'b1; start = 1'b0;

        run_conv(8'h9C, "m100");
        run_conv(8'h80, "m128");
        run_conv(8'h7F, "p127");
        run_conv(8'hFF, "ff");
        run_conv(8'd42, "p42");
        run_conv(8'd7, "p7");
        run_conv(8'd0, "zero");

        // Back-to-back with start held high
        @(negedge clk); val = 8'h9C; start = 1'b1;
        n = 0;
        while (done_d !== 1'b1 && n < 20) begin @(posedge clk); n++; @(negedge clk); end
        chk("b2b/first_lat", 64'(n), 64'd10);
        val = 8'h2A;
        set_expect(8'h9C); check_all("b2b1");
        m = 0;
        @(posedge clk); m++; @(negedge clk);
        while (done_d !== 1'b1 && m < 20) begin @(posedge clk); m++; @(negedge clk); end
        chk("b2b/period", 64'(m), 64'd10);
        start = 1'b0;
        set_expect(8'h2A); check_all("b2b2");

        // Start re-pulsed mid-conversion
        @(negedge clk); val = 8'hE7; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0; val = 8'h33;
        dones = 0; first = 0;
        for (int e = 1; e <= 14; e++) begin
            @(posedge clk); @(negedge clk);
            if (done_d === 1'b1) begin dones++; if (first == 0) first = e; end
            start = (e == 3 || e == 5);
        end
        start = 1'b0;
        chk("repulse/dones", 64'(dones), 64'd1);
        chk("repulse/edge", 64'(first), 64'd9);
        set_expect(8'hE7); check_all("repulse");

        // Reset during conversion
        @(negedge clk); val = 8'h55; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        rst = 1'b0;
        @(posedge clk); @(negedge clk);
        rst = 1'b1;
        chk("midrst/busy", 64'(busy_d), 64'd0);
        chk("midrst/done", 64'(done_d), 64'd0);
        e_d = '0; e_u = '0; e_2 = '0; e_b = '0;
        check_all("midrst");
        dones = 0;
        repeat (14) begin @(posedge clk); @(negedge clk); if (done_d === 1'b1) dones++; end
        chk("midrst/nodone", 64'(dones), 64'd0);
        run_conv(8'hC8, "after_rst");

        for (int i = 0; i < 20; i++) run_conv(8'($urandom_range(0, 255)), "rand");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
